// File: rtl/rom_port_arb.sv
// Arbitrates instruction fetch and JTAG debug accesses onto the single program-ROM port.
// Optional macro ROM_ARB_FETCH_BUF_EN adds a one-entry fetch buffer (valid, tag, data).
module rom_port_arb #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int MEM_NUM    = 4096,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_data,
  output logic          if_err,
  input  logic          halt,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_err,
  output logic          rom_wen,
  output logic          rom_ren,
  output logic [AW-1:0] rom_addr,
  output logic [DW-1:0] rom_wdata,
  input  logic [DW-1:0] rom_rdata
);

  localparam int RW = $clog2(STARVE_MAX + 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(STARVE_MAX);
  localparam logic [AW-1:0] WORD_LIM = AW'(MEM_NUM);

  typedef enum logic [1:0] {IDLE, IF_RD, DBG_RD, RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [RW-1:0] r_run, w_run_nxt;
  logic          r_owner_dbg;
  logic          r_err;
  logic [DW-1:0] r_if_data;
  logic [DW-1:0] r_dbg_rdata;

  logic          w_idle;
  logic          w_if_elig;
  logic          w_if_legal;
  logic          w_dbg_legal;
  logic          w_force_if;
  logic          w_gnt_dbg;
  logic          w_gnt_if;
  logic          w_if_hit;
  logic [DW-1:0] w_buf_data;

  function automatic logic addr_legal(input logic [AW-1:0] a);
    return (a[1:0] == 2'b00) && ({2'b00, a[AW-1:2]} < WORD_LIM);
  endfunction

  // Grants are only made from IDLE and are suppressed while reset is held.
  assign w_idle      = (r_state == IDLE) && !rst;
  assign w_if_elig   = if_req && !halt;
  assign w_if_legal  = addr_legal(if_addr);
  assign w_dbg_legal = addr_legal(dbg_addr);
  assign w_force_if  = w_if_elig && (r_run == RUN_MAX);
  assign w_gnt_dbg   = w_idle && dbg_req && !w_force_if;
  assign w_gnt_if    = w_idle && w_if_elig && !w_gnt_dbg;

`ifdef ROM_ARB_FETCH_BUF_EN
  logic          r_buf_vld;
  logic [AW-1:0] r_buf_tag;
  logic [DW-1:0] r_buf_data;

  assign w_if_hit   = r_buf_vld && (r_buf_tag == if_addr);
  assign w_buf_data = r_buf_data;

  // IF_RD is only reached by a legal fetch; if_addr is still held there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_vld  <= 1'b0;
      r_buf_tag  <= '0;
      r_buf_data <= '0;
    end else if (w_gnt_dbg && dbg_we && w_dbg_legal) begin
      r_buf_vld <= 1'b0;
    end else if (r_state == IF_RD) begin
      r_buf_vld  <= 1'b1;
      r_buf_tag  <= if_addr;
      r_buf_data <= rom_rdata;
    end
  end
`else
  assign w_if_hit   = 1'b0;
  assign w_buf_data = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    rom_wen     = 1'b0;
    rom_ren     = 1'b0;
    rom_addr    = '0;
    rom_wdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_dbg) begin
          if (!w_dbg_legal) begin
            w_state_nxt = RESP;
          end else if (dbg_we) begin
            rom_wen     = 1'b1;
            rom_addr    = dbg_addr;
            rom_wdata   = dbg_wdata;
            w_state_nxt = RESP;
          end else begin
            rom_ren     = 1'b1;
            rom_addr    = dbg_addr;
            w_state_nxt = DBG_RD;
          end
        end else if (w_gnt_if) begin
          if (!w_if_legal || w_if_hit) begin
            w_state_nxt = RESP;
          end else begin
            rom_ren     = 1'b1;
            rom_addr    = if_addr;
            w_state_nxt = IF_RD;
          end
        end
      end
      IF_RD:   w_state_nxt = RESP;
      DBG_RD:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Consecutive debug grants made while a fetch was waiting.
  always_comb begin
    w_run_nxt = r_run;
    if (r_state == IDLE) begin
      if (!w_if_elig || w_gnt_if) begin
        w_run_nxt = '0;
      end else if (w_gnt_dbg) begin
        w_run_nxt = r_run + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_run       <= '0;
      r_owner_dbg <= 1'b0;
      r_err       <= 1'b0;
      r_if_data   <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      if (w_gnt_dbg) begin
        r_owner_dbg <= 1'b1;
        r_err       <= !w_dbg_legal;
        if (!w_dbg_legal) r_dbg_rdata <= '0;
      end else if (w_gnt_if) begin
        r_owner_dbg <= 1'b0;
        r_err       <= !w_if_legal;
        if (!w_if_legal) r_if_data <= '0;
        else if (w_if_hit) r_if_data <= w_buf_data;
      end
      if (r_state == IF_RD)  r_if_data   <= rom_rdata;
      if (r_state == DBG_RD) r_dbg_rdata <= rom_rdata;
    end
  end

  assign if_ack    = (r_state == RESP) && !r_owner_dbg;
  assign dbg_ack   = (r_state == RESP) && r_owner_dbg;
  assign if_err    = if_ack && r_err;
  assign dbg_err   = dbg_ack && r_err;
  assign if_data   = r_if_data;
  assign dbg_rdata = r_dbg_rdata;

endmodule

// File: doc/rom_port_arb.md
# rom_port_arb

Single-port arbiter between the instruction-fetch path of the core, the JTAG debug memory port, and the on-chip program ROM. It serialises fetch reads, debug reads and debug writes onto the ROM's one port. It range-checks addresses and enforces a halt gate on fetch. It bounds fetch starvation while the debugger streams a program in. It sits between `jtag_top`/`riscv` and `rom` in `riscv_soc`.

## Interface
- `DW`, 32, data width
- `AW`, 32, byte-address width
- `MEM_NUM`, 4096, ROM depth in DW-bit words; legal byte addresses are 0 .. 4*MEM_NUM-4
- `STARVE_MAX`, 4, consecutive debug grants allowed while a fetch is pending (≥1)

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request, held with `if_addr` until `if_ack`.
- `if_addr` in AW: fetch byte address.
- `if_ack` out 1: one-cycle completion pulse.
- `if_data` out DW: fetched word, valid with `if_ack` and held until the next ack.
- `if_err` out 1: with `if_ack`, address illegal.
- `halt` in 1: from `jtag_top` halt_req; blocks new fetch grants.
- `dbg_req` in 1: debug request, held with payload until `dbg_ack`.
- `dbg_we` in 1: 1 = write, 0 = read.
- `dbg_addr` in AW: debug byte address.
- `dbg_wdata` in DW: debug write data.
- `dbg_ack` out 1: one-cycle completion pulse.
- `dbg_rdata` out DW: read word, valid with `dbg_ack` and held.
- `dbg_err` out 1: with `dbg_ack`, address illegal.
- `rom_wen` out 1: ROM write strobe.
- `rom_ren` out 1: ROM read strobe.
- `rom_addr` out AW: byte address to ROM.
- `rom_wdata` out DW: ROM write data.
- `rom_rdata` in DW: ROM read data, registered in ROM, valid the cycle after `rom_ren`.

## Operation
- FSM states are IDLE, IF_RD, DBG_RD and RESP. Reset enters IDLE.
- Request sampling and priority in IDLE:
  - Debug wins over fetch, except as stated in the starvation rule below.
  - A fetch is eligible only if `if_req && !halt`.
- Legal address: `addr[1:0]==0` and `addr[AW-1:2] < MEM_NUM`.
- Illegal address:
  - No ROM strobe is issued and the FSM goes directly to RESP.
  - The ack is returned with err=1 and data=0.
- Debug write (legal): `rom_wen=1`, `rom_addr=dbg_addr`, `rom_wdata=dbg_wdata` in the IDLE cycle, then RESP.
- Debug read (legal): `rom_ren=1` in IDLE, then DBG_RD.
  - DBG_RD captures `rom_rdata` into `dbg_rdata`, then RESP.
- Fetch (legal): `rom_ren=1` in IDLE, then IF_RD.
  - IF_RD captures `rom_rdata` into `if_data`, then RESP.
- RESP pulses the ack of the granted requester and returns to IDLE. Requests are not sampled in RESP.
- Requesters must change or drop their request on the edge after the ack.
- `rom_*` strobes are combinational from the IDLE grant decision. They are 0 in every other state.
- Starvation counter `run` (width $clog2(STARVE_MAX+1)):
  - It increments on each debug grant made while a fetch is eligible.
  - It clears on a fetch grant, or in any IDLE cycle where no fetch is eligible.
  - When `run==STARVE_MAX` and a fetch is eligible, IDLE grants the fetch even if `dbg_req=1`.
- `halt` is sampled only in IDLE. A fetch already in IF_RD/RESP completes normally.
- Asynchronous reset mid-operation:
  - State goes to IDLE and `run` clears.
  - All outputs go to 0, including held data registers.
  - The in-flight transfer is dropped with no ack.

## Timing
- Reset values: `if_ack`, `if_data`, `if_err`, `dbg_ack`, `dbg_rdata`, `dbg_err`, `rom_wen`, `rom_ren`, `rom_addr` and `rom_wdata` are all 0.
- With grant in cycle N:
  - A legal read acks in N+2.
  - A write, or any illegal access, acks in N+1.
- Throughput:
  - Back-to-back reads: 1 per 3 cycles.
  - Back-to-back writes: 1 per 2 cycles.
- Data outputs update on the edge that enters RESP and are held until the next capture.
- A write in cycle N followed by a read of the same address granted in N+2 returns the new data.

## Configuration
- Macro `ROM_ARB_FETCH_BUF_EN` adds a one-entry fetch buffer (valid, tag = `if_addr`, data).
- Buffer behaviour with the macro defined:
  - The buffer fills on each legal fetch capture.
  - A fetch that hits (valid, tag match) takes IDLE→RESP with no `rom_ren`, acking in N+1.
  - Any legal debug write clears valid. Reset clears valid.
  - A debug grant still has priority over a hit.
- Without the macro, every legal fetch goes to ROM with the 2-cycle latency above.

## Test plan
- Reset, then fetch of 0x0000_0010 with ROM word 4 = 0x0000_0013:
  - `rom_ren` and `rom_addr=0x10` appear in N.
  - `if_ack`, `if_data=0x0000_0013` and `if_err=0` appear in N+2.
- Debug write of 0xDEAD_BEEF to 0x20, then a debug read of 0x20:
  - The write asserts `rom_wen` in N and `dbg_ack` in N+1.
  - The read returns `dbg_rdata=0xDEAD_BEEF`.
- Illegal addresses, debug read of 0x0000_4000 (MEM_NUM=4096) and fetch of 0x2:
  - No ROM strobe is issued.
  - The ack comes one cycle after grant with err=1 and data=0.
- Starvation: `dbg_req` is held continuously while `if_req=1`, `halt=0` and STARVE_MAX=4.
  - Exactly 4 debug acks occur, then 1 fetch ack, and the pattern repeats.
  - With `halt=1`, zero fetch acks occur.
- Reset asserted in IF_RD: no `if_ack`, all outputs 0 immediately, and the next fetch after release behaves as in the first test.
- With `ROM_ARB_FETCH_BUF_EN`, fetch 0x10 twice: the second fetch acks in N+1 with no `rom_ren`. After a debug write to 0x10, the next fetch re-reads the ROM.
